// File: rtl/serial_word_loader.sv
// serial_word_loader: assembles MSB-first serial bits into a held WIDTH-bit word.
// Define SWL_PARITY_CHECK_EN to add a trailing even-parity bit per frame.
module serial_word_loader #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             busy,
  output logic             par_err,
  output logic [CNT_W-1:0] word_cnt
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
`ifdef SWL_PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_shift, r_word, w_word, w_load;
  logic [BW-1:0] r_bcnt;
  logic [CNT_W-1:0] r_cnt;
  logic r_valid, r_perr, w_last, w_accept, w_perr;
  assign w_word = {r_shift[WIDTH-2:0], ser_in};
  assign w_last = r_state == SHIFT && ser_valid && r_bcnt == LAST;
`ifdef SWL_PARITY_CHECK_EN
  logic w_par;
  assign w_par    = ^{r_shift, ser_in};
  assign w_accept = r_state == PARITY && ser_valid && !w_par;
  assign w_perr   = r_state == PARITY && ser_valid && w_par;
  assign w_load   = r_shift;
`else
  logic w_unused;
  assign w_unused = r_shift[WIDTH-1];
  assign w_accept = w_last;
  assign w_perr   = 1'b0;
  assign w_load   = w_word;
`endif
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && start) w_next = SHIFT;
`ifdef SWL_PARITY_CHECK_EN
    if (w_last) w_next = PARITY;
    if (r_state == PARITY && ser_valid) w_next = IDLE;
`else
    if (w_last) w_next = IDLE;
`endif
  end
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_bcnt  <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_valid <= w_accept;
      r_perr  <= w_perr;
      if (r_state == IDLE && start) r_bcnt <= '0;
      if (r_state == SHIFT && ser_valid) begin
        r_shift <= w_word;
        r_bcnt  <= r_bcnt + 1'b1;
      end
      if (w_accept) begin
        r_word <= w_load;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end
  assign word_out   = r_word;
  assign word_valid = r_valid;
  assign busy       = r_state != IDLE;
  assign par_err    = r_perr;
  assign word_cnt   = r_cnt;
endmodule

// File: tb/tb_serial_word_loader.sv
// tb_serial_word_loader: directed + randomized frames checked against a word/count model.
module tb_serial_word_loader;
  localparam int W = 10, CW = 8;
  logic clk = 1'b0, rst, start, ser_in, ser_valid;
  logic [W-1:0] word_out;
  logic word_valid, busy, par_err;
  logic [CW-1:0] word_cnt;
  int n_chk = 0, n_fail = 0, exp_cnt = 0;
  logic [W-1:0] exp_word = '0;

  serial_word_loader #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .ser_in(ser_in), .ser_valid(ser_valid),
    .word_out(word_out), .word_valid(word_valid), .busy(busy), .par_err(par_err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame starting in the current cycle; gap_n idle bits follow bit index gap_at.
  task automatic send(input logic [W-1:0] w, input int gap_at, input int gap_n, input bit bad, input bit stray);
    bit ok;
    start = 1'b1; ser_valid = 1'b1; ser_in = 1'($urandom);
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("valid_one_cycle", word_valid, 0);
    for (int i = W - 1; i >= 0; i--) begin
      ser_in = w[i]; ser_valid = 1'b1;
      tick();
      ser_valid = 1'b0;
`ifndef SWL_PARITY_CHECK_EN
      if (i > 0) begin
`endif
        check("mid_busy", busy, 1);
        check("mid_valid", word_valid, 0);
`ifndef SWL_PARITY_CHECK_EN
      end
`endif
      if (i == gap_at)
        for (int g = 0; g < gap_n; g++) begin
          start = stray; ser_in = 1'($urandom);
          tick();
          start = 1'b0;
          check("gap_valid", word_valid, 0);
        end
    end
`ifdef SWL_PARITY_CHECK_EN
    ser_in = ^w ^ bad; ser_valid = 1'b1;
    tick();
    ser_valid = 1'b0;
`endif
    ok = !bad;
    if (ok) begin
      exp_word = w;
      exp_cnt = (exp_cnt + 1) % (1 << CW);
    end
    check("done_busy", busy, 0);
    check("word_valid", word_valid, 32'(ok));
    check("par_err", par_err, 32'(!ok));
    check("word_out", word_out, 32'(exp_word));
    check("word_cnt", word_cnt, 32'(exp_cnt));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      ser_valid = 1'($urandom); ser_in = 1'($urandom);
      tick();
      check("idle_busy", busy, 0);
      check("idle_valid", word_valid, 0);
      check("idle_hold", word_out, 32'(exp_word));
    end
    ser_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ser_in = 1'b0; ser_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset_state", {word_out, word_valid, busy, par_err, word_cnt}, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_idle", {word_out, word_valid, busy, par_err, word_cnt}, 0);
    end
    send(10'h2CE, -1, 0, 1'b0, 1'b0);
    check("word_2ce", word_out, 32'h2CE);
    idle(20);
    check("hold_2ce", word_out, 32'h2CE);
    send(10'h2CE, W - 4, 3, 1'b0, 1'b1);
    idle(2);
    // Abort mid-frame; reset also beats a concurrent start.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ser_in = 1'($urandom); ser_valid = 1'b1; tick();
    end
    rst = 1'b1; start = 1'b1;
    tick();
    check("mid_reset", {word_out, word_valid, busy, par_err, word_cnt}, 0);
    rst = 1'b0; start = 1'b0; ser_valid = 1'b0;
    exp_word = '0; exp_cnt = 0;
    idle(2);
    send(10'h003, -1, 0, 1'b0, 1'b0);
    check("word_003", {word_out, word_cnt}, {10'h003, 8'd1});
    for (int f = 0; f < 8; f++) begin
      idle(1);
      send(W'($urandom), int'($urandom_range(1, W - 1)), int'($urandom_range(0, 4)), 1'b0, 1'($urandom));
    end
    rst = 1'b1; tick(); rst = 1'b0;
    exp_word = '0; exp_cnt = 0;
    for (int f = 0; f < 256; f++) send(W'($urandom), -1, 0, 1'b0, 1'b0);
    check("cnt_wrap", word_cnt, 0);
    idle(2);
`ifdef SWL_PARITY_CHECK_EN
    send(10'h2CE, -1, 0, 1'b0, 1'b0);
    check("par_accept", word_out, 32'h2CE);
    idle(1);
    send(10'h155, -1, 0, 1'b1, 1'b0);
    check("par_reject", word_out, 32'h2CE);
    tick();
    check("par_err_pulse", par_err, 0);
    for (int f = 0; f < 6; f++) begin
      idle(1);
      send(W'($urandom), int'($urandom_range(1, W - 1)), int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
